// File: rtl/jtag_mem_ctrl.sv
// Avalon-MM control/memory slave for the JTAG/ADC main unit: calibration CSRs,
// N_VEC byte-addressed vector buffers with a consumer port, and an ADC capture buffer.
module jtag_mem_ctrl #(
    parameter int unsigned N_VEC  = 2,
    parameter int unsigned VEC_AW = 12,
    localparam int unsigned RW    = VEC_AW - 2,
    localparam int unsigned AW    = RW + 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [AW-1:0]           address,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [31:0]             writedata,
    input  logic [3:0]              byteenable,
    output logic [31:0]             readdata,
    output logic                    readdatavalid,
    output logic                    irq,
    output logic [31:0]             tck_width,
    output logic [31:0]             tck_delay,
    output logic [31:0]             tms_delay,
    output logic [31:0]             tdi_delay,
    output logic [31:0]             tdo_delay,
    output logic [31:0]             adc_start_delay,
    output logic [31:0]             adc_config_odd,
    output logic [31:0]             adc_config_even,
    output logic                    jtag_rst,
    output logic                    jtag_rd,
    output logic                    jtag_wr,
    input  logic                    jtag_busy,
    input  logic [N_VEC*VEC_AW-1:0] vec_addr,
    input  logic [N_VEC-1:0]        vec_we,
    input  logic [N_VEC*8-1:0]      vec_wr_data,
    output logic [N_VEC*8-1:0]      vec_rd_data,
    input  logic                    adc_valid,
    input  logic [31:0]             adc_data
);

    localparam logic [2:0] ADC_REGION = 3'(N_VEC + 1);

    logic [2:0]    region;
    logic [RW-1:0] word;
    logic          cpu_wr, cpu_rd, csr_wr;

    // Storage
    logic [7:0]  vec_mem [N_VEC][2**VEC_AW];
    logic [31:0] adc_mem [2**RW];
    logic [N_VEC*8-1:0] vec_rd_q;

    // Control/status state
    logic [31:0]   cal_q [8];
    logic          adc_arm_q, irq_en_q, busy_q, done_q, wrap_q, coll_q, irq_q;
    logic          done_d, wrap_d, coll_d;
    logic [RW-1:0] adc_ptr_q, adc_ptr_d;
    logic          jtag_rst_q, jtag_rd_q, jtag_wr_q;
    logic [31:0]   rd1_q, readdata_q;
    logic          rd1_valid_q, readdatavalid_q;

    // Write steering and collision detection
    logic [N_VEC-1:0][3:0] vec_lane_we;
    logic                  vec_coll;
    logic                  cap_we, cpu_adc_wr, adc_coll, adc_cpu_we;
    logic                  ctrl_wr, status_wr, ptr_wr;
    logic [31:0]           csr_rdata, rd_mux;

    assign region  = address[AW-1:RW];
    assign word    = address[RW-1:0];
    assign cpu_wr  = chipselect & write;
    assign cpu_rd  = chipselect & read;
    assign csr_wr  = cpu_wr && (region == 3'd0);

    assign ctrl_wr   = csr_wr && (word == RW'(8));
    assign status_wr = csr_wr && (word == RW'(9)) && byteenable[0];
    // Any write to ADC_PTR rewinds the pointer, whatever the byte lanes.
    assign ptr_wr    = csr_wr && (word == RW'(10));

    assign cap_we     = adc_arm_q & adc_valid;
    assign cpu_adc_wr = cpu_wr && (region == ADC_REGION) && (|byteenable);
    // The capture write owns the whole word, so a clash drops every CPU lane.
    assign adc_coll   = cpu_adc_wr && cap_we && (word == adc_ptr_q);
    assign adc_cpu_we = cpu_adc_wr && !adc_coll;

    // Per-lane CPU vector writes; a lane hit by a consumer write is dropped
    always_comb begin
        vec_lane_we = '0;
        vec_coll    = 1'b0;
        for (int k = 0; k < N_VEC; k++) begin
            for (int b = 0; b < 4; b++) begin
                if (cpu_wr && (region == 3'(k + 1)) && byteenable[b]) begin
                    if (vec_we[k] && (vec_addr[k*VEC_AW +: VEC_AW] == {word, 2'(b)})) begin
                        vec_coll = 1'b1;
                    end else begin
                        vec_lane_we[k][b] = 1'b1;
                    end
                end
            end
        end
    end

    // Vector buffers: consumer port (write-first read) and CPU byte lanes
    always_ff @(posedge clk) begin
        for (int k = 0; k < N_VEC; k++) begin
            if (vec_we[k]) begin
                vec_mem[k][vec_addr[k*VEC_AW +: VEC_AW]] <= vec_wr_data[k*8 +: 8];
            end
            for (int b = 0; b < 4; b++) begin
                if (vec_lane_we[k][b]) begin
                    vec_mem[k][{word, 2'(b)}] <= writedata[8*b +: 8];
                end
            end
            vec_rd_q[k*8 +: 8] <= vec_we[k] ? vec_wr_data[k*8 +: 8]
                                            : vec_mem[k][vec_addr[k*VEC_AW +: VEC_AW]];
        end
    end

    assign vec_rd_data = vec_rd_q;

    // ADC buffer: capture write at the pointer plus CPU byte-lane writes
    always_ff @(posedge clk) begin
        if (cap_we) begin
            adc_mem[adc_ptr_q] <= adc_data;
        end
        if (adc_cpu_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) adc_mem[word][8*b +: 8] <= writedata[8*b +: 8];
            end
        end
    end

    // Sticky status and capture pointer next state; a set beats a same-cycle clear
    always_comb begin
        done_d    = busy_q & ~jtag_busy;
        wrap_d    = cap_we && (adc_ptr_q == '1);
        coll_d    = vec_coll | adc_coll;
        adc_ptr_d = adc_ptr_q;
        if (!(status_wr && writedata[1])) done_d = done_d | done_q;
        if (!((status_wr && writedata[2]) || ptr_wr)) wrap_d = wrap_d | wrap_q;
        if (!(status_wr && writedata[3])) coll_d = coll_d | coll_q;
        if (ptr_wr) begin
            adc_ptr_d = '0;
        end else if (cap_we) begin
            adc_ptr_d = adc_ptr_q + RW'(1);
        end
    end

    // CSR readback for region 0
    always_comb begin
        csr_rdata = 32'h0;
        if (word < RW'(8)) begin
            csr_rdata = cal_q[word[2:0]];
        end else if (word == RW'(8)) begin
            csr_rdata = {22'h0, irq_en_q, adc_arm_q, 8'h0};
        end else if (word == RW'(9)) begin
            csr_rdata = {28'h0, coll_q, wrap_q, done_q, jtag_busy};
        end else if (word == RW'(10)) begin
            csr_rdata = 32'(adc_ptr_q);
        end else if (word == RW'(11)) begin
            csr_rdata = {8'hA5, 8'(N_VEC), 8'(VEC_AW), 8'h01};
        end
    end

    // Region read mux; unmapped regions return a recognisable pattern
    always_comb begin
        rd_mux = 32'h8765_4321;
        if (region == 3'd0) begin
            rd_mux = csr_rdata;
        end else if (region == ADC_REGION) begin
            rd_mux = adc_mem[word];
        end
        for (int k = 0; k < N_VEC; k++) begin
            if (region == 3'(k + 1)) begin
                rd_mux = {vec_mem[k][{word, 2'd3}], vec_mem[k][{word, 2'd2}],
                          vec_mem[k][{word, 2'd1}], vec_mem[k][{word, 2'd0}]};
            end
        end
    end

    // Calibration registers with byte-lane writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) cal_q[i] <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                for (int b = 0; b < 4; b++) begin
                    if (csr_wr && (word == RW'(i)) && byteenable[b]) begin
                        cal_q[i][8*b +: 8] <= writedata[8*b +: 8];
                    end
                end
            end
        end
    end

    // Control levels, command pulses, status flags, pointer, irq and read pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adc_arm_q       <= 1'b0;
            irq_en_q        <= 1'b0;
            jtag_rst_q      <= 1'b0;
            jtag_rd_q       <= 1'b0;
            jtag_wr_q       <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            wrap_q          <= 1'b0;
            coll_q          <= 1'b0;
            irq_q           <= 1'b0;
            adc_ptr_q       <= '0;
            rd1_q           <= '0;
            rd1_valid_q     <= 1'b0;
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
        end else begin
            if (ctrl_wr && byteenable[1]) begin
                adc_arm_q <= writedata[8];
                irq_en_q  <= writedata[9];
            end
            jtag_rst_q      <= ctrl_wr && byteenable[0] && writedata[0];
            jtag_rd_q       <= ctrl_wr && byteenable[0] && writedata[1];
            jtag_wr_q       <= ctrl_wr && byteenable[0] && writedata[2];
            busy_q          <= jtag_busy;
            done_q          <= done_d;
            wrap_q          <= wrap_d;
            coll_q          <= coll_d;
            irq_q           <= irq_en_q & done_q;
            adc_ptr_q       <= adc_ptr_d;
            rd1_q           <= rd_mux;
            rd1_valid_q     <= cpu_rd;
            readdata_q      <= rd1_valid_q ? rd1_q : 32'h0;
            readdatavalid_q <= rd1_valid_q;
        end
    end

    assign readdata        = readdata_q;
    assign readdatavalid   = readdatavalid_q;
    assign irq             = irq_q;
    assign jtag_rst        = jtag_rst_q;
    assign jtag_rd         = jtag_rd_q;
    assign jtag_wr         = jtag_wr_q;
    assign tck_width       = cal_q[0];
    assign tck_delay       = cal_q[1];
    assign tms_delay       = cal_q[2];
    assign tdi_delay       = cal_q[3];
    assign tdo_delay       = cal_q[4];
    assign adc_start_delay = cal_q[5];
    assign adc_config_odd  = cal_q[6];
    assign adc_config_even = cal_q[7];

endmodule

// File: tb/tb_jtag_mem_ctrl.sv
// Scoreboard bench for jtag_mem_ctrl: reads push expected data and arrival cycle,
// a negedge monitor pops and compares whenever readdatavalid is seen.
module tb_jtag_mem_ctrl;

    localparam int N_VEC  = 2;
    localparam int VEC_AW = 12;
    localparam int AW     = 13;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [AW-1:0]           address;
    logic                    chipselect, read, write;
    logic [31:0]             writedata;
    logic [3:0]              byteenable;
    logic [31:0]             readdata;
    logic                    readdatavalid, irq;
    logic [31:0]             tck_width, tck_delay, tms_delay, tdi_delay, tdo_delay;
    logic [31:0]             adc_start_delay, adc_config_odd, adc_config_even;
    logic                    jtag_rst, jtag_rd, jtag_wr, jtag_busy;
    logic [N_VEC*VEC_AW-1:0] vec_addr;
    logic [N_VEC-1:0]        vec_we;
    logic [N_VEC*8-1:0]      vec_wr_data, vec_rd_data;
    logic                    adc_valid;
    logic [31:0]             adc_data;

    jtag_mem_ctrl #(.N_VEC(N_VEC), .VEC_AW(VEC_AW)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .read(read), .write(write), .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata), .readdatavalid(readdatavalid), .irq(irq),
        .tck_width(tck_width), .tck_delay(tck_delay), .tms_delay(tms_delay),
        .tdi_delay(tdi_delay), .tdo_delay(tdo_delay), .adc_start_delay(adc_start_delay),
        .adc_config_odd(adc_config_odd), .adc_config_even(adc_config_even),
        .jtag_rst(jtag_rst), .jtag_rd(jtag_rd), .jtag_wr(jtag_wr), .jtag_busy(jtag_busy),
        .vec_addr(vec_addr), .vec_we(vec_we), .vec_wr_data(vec_wr_data),
        .vec_rd_data(vec_rd_data), .adc_valid(adc_valid), .adc_data(adc_data)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Monitor: every readdatavalid must match the oldest outstanding read
    always @(negedge clk) begin
        if (!reset && readdatavalid) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rdv: readdata=%h with no read outstanding", readdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (readdata !== mon_e.data || cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL %s: got %h at cycle %0d, expected %h at cycle %0d",
                             mon_e.name, readdata, cyc, mon_e.data, mon_e.cyc);
                end
            end
        end
    end

    function automatic logic [AW-1:0] addr_of(int r, int w);
        return AW'(r * 1024 + w);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // All bus tasks are entered at a negedge and return at the next negedge
    task automatic bus_write(logic [AW-1:0] a, logic [31:0] d, logic [3:0] be);
        address = a; writedata = d; byteenable = be; chipselect = 1'b1; write = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0; byteenable = 4'h0;
    endtask

    task automatic bus_read(logic [AW-1:0] a, logic [31:0] exp, string name);
        exp_t e;
        e.data = exp; e.cyc = cyc + 2; e.name = name;
        exp_q.push_back(e);
        address = a; chipselect = 1'b1; read = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
    endtask

    initial begin
        reset = 1'b1; address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        writedata = '0; byteenable = '0; jtag_busy = 1'b0; vec_addr = '0; vec_we = '0;
        vec_wr_data = '0; adc_valid = 1'b0; adc_data = '0;
        repeat (3) @(negedge clk);
        check("reset_readdata", readdata, 32'h0);
        check("reset_rdv", {31'h0, readdatavalid}, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        check("reset_pulses", {29'h0, jtag_rst, jtag_rd, jtag_wr}, 32'h0);
        check("reset_tck_width", tck_width, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // CSR byte lanes, ID, unmapped words and regions
        bus_write(addr_of(0, 0), 32'h1234_5678, 4'b0011);
        check("tck_width_port", tck_width, 32'h0000_5678);
        bus_read(addr_of(0, 0), 32'h0000_5678, "tck_width_rd");
        bus_read(addr_of(0, 11), 32'hA502_0C01, "id_rd");
        bus_read(addr_of(0, 12), 32'h0, "csr_hole_rd");
        bus_read(addr_of(7, 0), 32'h8765_4321, "unmapped_region_rd");
        bus_write(addr_of(0, 7), 32'hCAFE_F00D, 4'hF);
        bus_read(addr_of(0, 7), 32'hCAFE_F00D, "adc_config_even_rd");
        check("adc_config_even_port", adc_config_even, 32'hCAFE_F00D);

        // Command pulses last exactly one cycle
        bus_write(addr_of(0, 8), 32'h0000_0107, 4'hF);
        check("pulses_high", {29'h0, jtag_rst, jtag_rd, jtag_wr}, 32'h7);
        @(negedge clk);
        check("pulses_low", {29'h0, jtag_rst, jtag_rd, jtag_wr}, 32'h0);
        bus_read(addr_of(0, 8), 32'h0000_0100, "control_rd");
        bus_write(addr_of(0, 8), 32'h0, 4'hF);

        // Vector buffer 1 via CPU, consumer read of byte 22
        bus_write(addr_of(2, 5), 32'hDDCC_BBAA, 4'hF);
        vec_addr[2*VEC_AW-1:VEC_AW] = 12'd22;
        @(negedge clk);
        check("vec1_byte22", {24'h0, vec_rd_data[15:8]}, 32'hCC);
        bus_read(addr_of(2, 5), 32'hDDCC_BBAA, "vec1_w5_rd");
        bus_write(addr_of(2, 6), 32'h0, 4'hF);
        bus_write(addr_of(2, 6), 32'hAABB_CCDD, 4'b0101);
        bus_read(addr_of(2, 6), 32'h00BB_00DD, "vec1_w6_be_rd");

        // Consumer write-first on channel 0
        vec_addr[VEC_AW-1:0] = 12'd100; vec_wr_data[7:0] = 8'h77; vec_we[0] = 1'b1;
        @(negedge clk);
        vec_we[0] = 1'b0;
        check("vec0_write_first", {24'h0, vec_rd_data[7:0]}, 32'h77);

        // Vector collision on byte 20: consumer wins that lane only
        vec_addr[2*VEC_AW-1:VEC_AW] = 12'd20; vec_wr_data[15:8] = 8'h55; vec_we[1] = 1'b1;
        bus_write(addr_of(2, 5), 32'h1122_3344, 4'hF);
        vec_we[1] = 1'b0;
        bus_read(addr_of(2, 5), 32'h1122_3355, "vec_coll_data_rd");
        bus_read(addr_of(0, 9), 32'h8, "vec_coll_status_rd");
        bus_write(addr_of(0, 9), 32'h8, 4'h1);
        bus_read(addr_of(0, 9), 32'h0, "coll_cleared_rd");

        // ADC capture: 1025 samples wrap the 1024-word buffer
        bus_write(addr_of(0, 8), 32'h0000_0100, 4'hF);
        for (int i = 0; i < 1025; i++) begin
            adc_valid = 1'b1; adc_data = 32'(i);
            @(negedge clk);
        end
        adc_valid = 1'b0;
        bus_read(addr_of(0, 10), 32'h1, "adc_ptr_rd");
        bus_read(addr_of(0, 9), 32'h4, "adc_wrap_status_rd");
        bus_read(addr_of(3, 0), 32'd1024, "adc_w0_rd");
        bus_read(addr_of(3, 1), 32'd1, "adc_w1_rd");
        bus_read(addr_of(3, 1023), 32'd1023, "adc_w1023_rd");

        // ADC collision: capture wins the word, pointer still advances
        bus_write(addr_of(0, 10), 32'h0, 4'hF);
        adc_valid = 1'b1; adc_data = 32'h0000_BEEF;
        bus_write(addr_of(3, 0), 32'hDEAD_0000, 4'hF);
        adc_valid = 1'b0;
        bus_read(addr_of(3, 0), 32'h0000_BEEF, "adc_coll_data_rd");
        bus_read(addr_of(0, 9), 32'h8, "adc_coll_status_rd");
        bus_read(addr_of(0, 10), 32'h1, "adc_ptr_after_coll_rd");

        // Same-cycle capture and CPU read of that word returns old data
        adc_valid = 1'b1; adc_data = 32'h0000_0999;
        bus_read(addr_of(3, 1), 32'd1, "adc_read_old_rd");
        adc_valid = 1'b0;
        bus_read(addr_of(3, 1), 32'h0000_0999, "adc_read_new_rd");

        // Disarmed: adc_valid ignored
        bus_write(addr_of(0, 8), 32'h0, 4'hF);
        bus_write(addr_of(0, 9), 32'h8, 4'h1);
        adc_valid = 1'b1; adc_data = 32'h1;
        @(negedge clk);
        adc_valid = 1'b0;
        bus_read(addr_of(0, 10), 32'h2, "adc_ptr_disarmed_rd");
        bus_read(addr_of(0, 9), 32'h0, "status_clean_rd");

        // done / irq on jtag_busy falling
        bus_write(addr_of(0, 8), 32'h0000_0200, 4'hF);
        jtag_busy = 1'b1;
        @(negedge clk);
        bus_read(addr_of(0, 9), 32'h1, "busy_live_rd");
        jtag_busy = 1'b0;
        @(negedge clk);
        check("irq_not_yet", {31'h0, irq}, 32'h0);
        @(negedge clk);
        check("irq_set", {31'h0, irq}, 32'h1);
        bus_read(addr_of(0, 9), 32'h2, "done_rd");
        bus_write(addr_of(0, 9), 32'h2, 4'h1);
        @(negedge clk);
        check("irq_cleared", {31'h0, irq}, 32'h0);
        bus_read(addr_of(0, 9), 32'h0, "done_cleared_rd");

        // Clear in the same cycle as a new falling edge: set wins
        jtag_busy = 1'b1;
        @(negedge clk);
        jtag_busy = 1'b0;
        bus_write(addr_of(0, 9), 32'h2, 4'h1);
        bus_read(addr_of(0, 9), 32'h2, "done_set_wins_rd");
        check("irq_after_set_wins", {31'h0, irq}, 32'h1);
        bus_write(addr_of(0, 9), 32'h2, 4'h1);
        @(negedge clk);
        check("irq_final_clear", {31'h0, irq}, 32'h0);

        // Drain outstanding reads with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            vectors++;
            errors++;
            $display("FAIL drain: %0d reads outstanding, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
